// File: rtl/mitll_dfft_pkg.sv
// Shared definitions for the DFFT toggle-output deserializer: decoder state
// and the DFFT clock-to-out delay used when offsetting the sampled stream.
package mitll_dfft_pkg;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam real DFFT_DELAY_PS = 7.7;

endpackage

// File: rtl/mitll_toggle_decode.sv
// Converts the edge-encoded DFFT output into one bit per enabled sample:
// a transition relative to the previous known sample is a 1, no transition a 0.
module mitll_toggle_decode
    import mitll_dfft_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    input  logic en,
    output logic bit_val,
    output logic bit_vld,
    output logic x_smp
);

    state_t state;
    state_t state_nxt;
    logic   ref_q;
    logic   unknown;

    // Timing violations in the DFFT show up as X/Z; such samples are ignored.
    assign unknown = $isunknown(din);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= PRIME;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == PRIME && en && !unknown) begin
            state_nxt = RUN;
        end
    end

    always_comb begin
        bit_val = din ^ ref_q;
        bit_vld = en && !unknown && (state == RUN);
        x_smp   = unknown;
    end

    // Reference follows every known sample, even while disabled, so that
    // re-enabling never decodes a stale transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_q <= 1'b0;
        end else if (!unknown) begin
            ref_q <= din;
        end
    end

endmodule

// File: rtl/mitll_dfft_deser.sv
// Deserializer for the DFFT toggle stream: assembles WORD_W decoded bits
// (first bit at the MSB) and offers each word on a valid/ready handshake.
module mitll_dfft_deser
    import mitll_dfft_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int CNT_W  = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    input  logic              en,
    input  logic              out_ready,
    input  logic              sticky_clr,
    output logic [WORD_W-1:0] out_word,
    output logic              out_valid,
    output logic [CNT_W-1:0]  bit_cnt,
    output logic              overflow,
    output logic              xerr
);

    logic              bit_val;
    logic              bit_vld;
    logic              x_smp;
    logic [WORD_W-2:0] shift;
    logic [WORD_W-1:0] new_word;
    logic              complete;
    logic              accept;
    logic              load;
    logic              drop;

    mitll_toggle_decode u_decode (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (din),
        .en      (en),
        .bit_val (bit_val),
        .bit_vld (bit_vld),
        .x_smp   (x_smp)
    );

    assign new_word = {shift, bit_val};
    assign complete = bit_vld && (bit_cnt == CNT_W'(WORD_W - 1));
    assign accept   = out_valid && out_ready;
    // A word leaving this edge frees the output register for the new one.
    assign load     = complete && (!out_valid || out_ready);
    assign drop     = complete && out_valid && !out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift     <= '0;
            bit_cnt   <= '0;
            out_word  <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            xerr      <= 1'b0;
        end else begin
            if (bit_vld) begin
                shift   <= new_word[WORD_W-2:0];
                bit_cnt <= complete ? '0 : bit_cnt + CNT_W'(1);
            end

            if (load) begin
                out_word  <= new_word;
                out_valid <= 1'b1;
            end else if (accept) begin
                out_valid <= 1'b0;
            end

            // Set events take priority over a coincident clear.
            if (drop) begin
                overflow <= 1'b1;
            end else if (sticky_clr) begin
                overflow <= 1'b0;
            end

            if (x_smp) begin
                xerr <= 1'b1;
            end else if (sticky_clr) begin
                xerr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mitll_dfft_deser.sv
// Bench for mitll_dfft_deser: behavioural model plus a word scoreboard.
`timescale 1ps/1ps
module tb_mitll_dfft_deser;
    import mitll_dfft_pkg::*;

    localparam int WORD_W = 8;
    localparam int CNT_W  = $clog2(WORD_W + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              din = 1'b0;
    logic              en = 1'b0;
    logic              out_ready = 1'b0;
    logic              sticky_clr = 1'b0;
    logic [WORD_W-1:0] out_word;
    logic              out_valid;
    logic [CNT_W-1:0]  bit_cnt;
    logic              overflow;
    logic              xerr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WORD_W-1:0] exp_q[$];

    logic              m_ref, m_primed, m_valid, m_ovf, m_xerr;
    logic [WORD_W-1:0] m_acc, m_word;
    int                m_cnt;

    mitll_dfft_deser #(.WORD_W(WORD_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .en         (en),
        .out_ready  (out_ready),
        .sticky_clr (sticky_clr),
        .out_word   (out_word),
        .out_valid  (out_valid),
        .bit_cnt    (bit_cnt),
        .overflow   (overflow),
        .xerr       (xerr)
    );

    always #10000 clk = ~clk;

    initial begin
        #100_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ref = 1'b0; m_primed = 1'b0; m_valid = 1'b0; m_ovf = 1'b0; m_xerr = 1'b0;
        m_acc = '0; m_word = '0; m_cnt = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        din = 1'b0; en = 1'b0; out_ready = 1'b0; sticky_clr = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock: drive inputs after the DFFT delay, score handshakes, update model, compare.
    task automatic step(input logic d, input logic e, input logic rdy, input logic clr);
        logic b, bv, xs, drop;
        #(DFFT_DELAY_PS);
        din = d; en = e; out_ready = rdy; sticky_clr = clr;
        @(negedge clk);
        if (out_valid === 1'b1 && rdy) begin
            check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("sb_word", 32'(out_word), 32'(exp_q.pop_front()));
        end
        xs = $isunknown(d); bv = 1'b0; b = 1'b0; drop = 1'b0;
        if (!xs) begin
            if (e && m_primed) begin
                bv = 1'b1;
                b  = d ^ m_ref;
            end
            if (e) m_primed = 1'b1;
            m_ref = d;
        end
        if (m_valid && rdy) m_valid = 1'b0;
        if (bv) begin
            m_acc = {m_acc[WORD_W-2:0], b};
            m_cnt++;
            if (m_cnt == WORD_W) begin
                m_cnt = 0;
                if (!m_valid) begin
                    m_word  = m_acc;
                    m_valid = 1'b1;
                    exp_q.push_back(m_acc);
                end else begin
                    drop = 1'b1;
                end
            end
        end
        if (drop) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
        if (xs) m_xerr = 1'b1; else if (clr) m_xerr = 1'b0;
        @(posedge clk);
        #1;
        check("bit_cnt", 32'(bit_cnt), 32'(m_cnt));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("xerr", 32'(xerr), 32'(m_xerr));
        if (m_valid) check("out_word", 32'(out_word), 32'(m_word));
    endtask

    initial begin
        logic       probe;
        logic [7:0] t1_din;
        model_reset();
        #1;
        check("rst_out_word", 32'(out_word), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_bit_cnt", 32'(bit_cnt), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_xerr", 32'(xerr), 32'd0);

        // Test 1: prime at edge 1, toggles at edges 2,3,5,9.
        do_reset();
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("t1_prime_cnt", 32'(bit_cnt), 32'd0);
        t1_din = 8'b1001_1110;
        for (int i = 7; i >= 0; i--) step(t1_din[i], 1'b1, 1'b1, 1'b0);
        check("t1_word", 32'(out_word), 32'hD1);
        check("t1_valid", 32'(out_valid), 32'd1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("t1_valid_one_cycle", 32'(out_valid), 32'd0);

        // Test 2: ready held low, two completions.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        check("t2_overflow", 32'(overflow), 32'd1);
        check("t2_held_word", 32'(out_word), 32'h00);
        check("t2_held_valid", 32'(out_valid), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("t2_clr", 32'(overflow), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0);

        // Test 3: completion coincides with acceptance.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(din ^ 1'b1, 1'b1, 1'b0, 1'b0);
        check("t3_first", 32'(out_word), 32'hFF);
        for (int i = 0; i < 7; i++) step(din, 1'b1, 1'b0, 1'b0);
        step(din ^ 1'b1, 1'b1, 1'b1, 1'b0);
        check("t3_valid_kept", 32'(out_valid), 32'd1);
        check("t3_no_overflow", 32'(overflow), 32'd0);
        check("t3_second", 32'(out_word), 32'h01);
        step(din, 1'b1, 1'b1, 1'b0);

        // Test 4: unknown sample mid-word (needs a 4-state simulator).
        probe = 1'bx;
        if ($isunknown(probe)) begin
            do_reset();
            step(1'b0, 1'b1, 1'b1, 1'b0);
            for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
            step(1'bx, 1'b1, 1'b1, 1'b0);
            check("t4_xerr", 32'(xerr), 32'd1);
            check("t4_cnt_hold", 32'(bit_cnt), 32'd3);
            step(1'b1, 1'b1, 1'b1, 1'b0);
            check("t4_cnt_after", 32'(bit_cnt), 32'd4);
            step(1'b1, 1'b1, 1'b1, 1'b1);
            check("t4_xerr_clr", 32'(xerr), 32'd0);
        end else begin
            $display("note: 2-state simulator, X-sample scenario skipped");
        end

        // Test 5: enable paused while din toggles twice.
        do_reset();
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("t5_cnt_paused", 32'(bit_cnt), 32'd3);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("t5_cnt_resume", 32'(bit_cnt), 32'd4);
        for (int i = 0; i < 4; i++) step(din ^ 1'(i), 1'b1, 1'b1, 1'b0);
        check("t5_word", 32'(out_word), 32'b1010_0101);

        // Test 6: asynchronous reset mid-word with a word held.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 13; i++) step(1'(i & 1), 1'b1, 1'b0, 1'b0);
        check("t6_pre_cnt", 32'(bit_cnt), 32'd5);
        check("t6_pre_valid", 32'(out_valid), 32'd1);
        #5000;
        rst_n = 1'b0;
        en = 1'b0;
        #1;
        check("t6_rst_word", 32'(out_word), 32'd0);
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_cnt", 32'(bit_cnt), 32'd0);
        check("t6_rst_overflow", 32'(overflow), 32'd0);
        model_reset();
        din = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("t6_prime_only", 32'(bit_cnt), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("t6_first_bit", 32'(bit_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
